// File: rtl/store_narrow_unit_pkg.sv
// store_narrow_unit_pkg
//   Shared definitions for the store narrowing path: store size encodings,
//   the store FSM state encoding and small helpers for offset handling.
//   Imported by store_narrow_unit and store_lane_merge.
package store_narrow_unit_pkg;

  // Store size encodings as carried on ReqSize.
  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;
  localparam logic [1:0] SIZE_RSVD = 2'b11;

  // Store FSM states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_READ  = 2'b01,
    ST_WRITE = 2'b10,
    ST_ERR   = 2'b11
  } state_t;

  // A half store must sit on an even byte address. A word store must sit on
  // a multiple of four. Byte and reserved sizes are never misaligned.
  function automatic logic is_misaligned(input logic [1:0] size,
                                         input logic [1:0] offset);
    case (size)
      SIZE_HALF: return offset[0];
      SIZE_WORD: return (offset != 2'b00);
      default:   return 1'b0;
    endcase
  endfunction

  // Drop the low offset bits that a given size cannot use.
  function automatic logic [1:0] align_offset(input logic [1:0] size,
                                              input logic [1:0] offset);
    case (size)
      SIZE_HALF: return {offset[1], 1'b0};
      SIZE_WORD: return 2'b00;
      default:   return offset;
    endcase
  endfunction

endpackage

// File: rtl/store_lane_merge.sv
// store_lane_merge
//   Combinational little-endian lane merge. Places the narrowed store data
//   into the addressed lane(s) of an existing memory word and keeps all other
//   lanes. Also intended for the load/store forwarding unit.
// Ports:
//   old_word  in  32  current memory word
//   new_data  in  32  register value; only the low bytes of the size are used
//   size      in  2   SIZE_BYTE / SIZE_HALF / SIZE_WORD / SIZE_RSVD
//   offset    in  2   byte offset inside the word (half uses offset[1] only)
//   merged    out 32  resulting word
module store_lane_merge
  import store_narrow_unit_pkg::*;
(
  input  logic [31:0] old_word,
  input  logic [31:0] new_data,
  input  logic [1:0]  size,
  input  logic [1:0]  offset,
  output logic [31:0] merged
);

  always_comb begin
    merged = old_word;
    case (size)
      SIZE_BYTE: begin
        case (offset)
          2'd0:    merged[7:0]   = new_data[7:0];
          2'd1:    merged[15:8]  = new_data[7:0];
          2'd2:    merged[23:16] = new_data[7:0];
          default: merged[31:24] = new_data[7:0];
        endcase
      end
      SIZE_HALF: begin
        if (offset[1]) merged[31:16] = new_data[15:0];
        else           merged[15:0]  = new_data[15:0];
      end
      SIZE_WORD: merged = new_data;
      default:   merged = old_word;
    endcase
  end

endmodule

// File: rtl/store_narrow_unit.sv
// store_narrow_unit
//   Store-path formatter between the EX/MEM register and the word-wide data
//   memory. Word stores are written directly; byte and half stores do a
//   read-modify-write (one read cycle, then a merged write cycle).
//   Optional build macro: STORE_MISALIGN_TRAP_EN
//     defined   -> misaligned half/word requests retire through ERR with a
//                  Done+Misaligned pulse and no memory access
//     undefined -> low address bits are force-aligned, Misaligned is tied 0
// Ports:
//   Clk, Reset_n            clock, synchronous active-low reset
//   ReqValid/ReqReady       request handshake
//   ReqAddr/ReqData/ReqSize byte address, register value, size code
//   MemAddr                 latched word address to data memory
//   MemRdEn/MemRdData       read strobe, read data valid the following cycle
//   MemWrEn/MemWrData       write strobe and full word to write
//   Done, Misaligned, Busy  retirement pulse, trap pulse, not-idle flag
//   dbg_state               current FSM state
//
// Handshake: a request transfers on the rising edge where ReqValid and
// ReqReady are both high; ReqReady is high only in IDLE and depends on state
// alone, so a held ReqValid is taken on the first IDLE edge and nothing is
// dropped while ReqReady is low.
module store_narrow_unit
  import store_narrow_unit_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              ReqValid,
  output logic              ReqReady,
  input  logic [31:0]       ReqAddr,
  input  logic [31:0]       ReqData,
  input  logic [1:0]        ReqSize,
  output logic [ADDR_W-1:0] MemAddr,
  output logic              MemRdEn,
  input  logic [31:0]       MemRdData,
  output logic              MemWrEn,
  output logic [31:0]       MemWrData,
  output logic              Done,
  output logic              Misaligned,
  output logic              Busy,
  output logic [1:0]        dbg_state
);

  state_t             state;
  state_t             next_state;
  logic [ADDR_W-1:0]  addr_q;
  logic [31:0]        data_q;
  logic [1:0]         size_q;
  logic [1:0]         off_q;
  logic [31:0]        merged;
  logic               accept;
  logic               trap;
  logic               sub_word;

  // Address bits above the memory range wrap silently.
  logic unused_addr_hi;
  assign unused_addr_hi = ^ReqAddr[31:ADDR_W+2];

  assign accept   = ReqValid && (state == ST_IDLE);
  assign sub_word = (ReqSize == SIZE_BYTE) || (ReqSize == SIZE_HALF);

`ifdef STORE_MISALIGN_TRAP_EN
  assign trap = is_misaligned(ReqSize, ReqAddr[1:0]);
`else
  assign trap = 1'b0;
`endif

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state  <= ST_IDLE;
      addr_q <= '0;
      data_q <= '0;
      size_q <= SIZE_BYTE;
      off_q  <= 2'b00;
    end else begin
      state <= next_state;
      if (accept) begin
        addr_q <= ReqAddr[ADDR_W+1:2];
        data_q <= ReqData;
        size_q <= ReqSize;
        off_q  <= align_offset(ReqSize, ReqAddr[1:0]);
      end
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: begin
        if (ReqValid) begin
          if (trap)          next_state = ST_ERR;
          else if (sub_word) next_state = ST_READ;
          else               next_state = ST_WRITE;  // word, or reserved no-op
        end
      end
      ST_READ:  next_state = ST_WRITE;
      ST_WRITE: next_state = ST_IDLE;
      ST_ERR:   next_state = ST_IDLE;
      default:  next_state = ST_IDLE;
    endcase
  end

  // For word stores the merge returns data_q and ignores MemRdData.
  store_lane_merge u_merge (
    .old_word (MemRdData),
    .new_data (data_q),
    .size     (size_q),
    .offset   (off_q),
    .merged   (merged)
  );

  assign ReqReady  = (state == ST_IDLE);
  assign Busy      = (state != ST_IDLE);
  assign MemAddr   = addr_q;
  assign MemRdEn   = (state == ST_READ);
  // A reserved size still passes through WRITE to pulse Done, but never writes.
  assign MemWrEn   = (state == ST_WRITE) && (size_q != SIZE_RSVD);
  assign MemWrData = MemWrEn ? merged : 32'h0;
  assign Done      = (state == ST_WRITE) || (state == ST_ERR);
`ifdef STORE_MISALIGN_TRAP_EN
  assign Misaligned = (state == ST_ERR);
`else
  assign Misaligned = 1'b0;
`endif
  assign dbg_state = state;

endmodule

// File: tb/tb_store_narrow_unit.sv
// tb_store_narrow_unit
//   Self-checking bench for store_narrow_unit: directed cases with literal
//   expectations, then randomized requests checked every cycle against a
//   schedule-based reference model with its own copy of memory.
module tb_store_narrow_unit;
  localparam int ADDR_W = 10;
  localparam int DEPTH  = 1 << ADDR_W;
`ifdef STORE_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  // ---------------- clock / reset / DUT ----------------
  logic              Clk;
  logic              Reset_n;
  logic              ReqValid;
  logic              ReqReady;
  logic [31:0]       ReqAddr;
  logic [31:0]       ReqData;
  logic [1:0]        ReqSize;
  logic [ADDR_W-1:0] MemAddr;
  logic              MemRdEn;
  logic [31:0]       MemRdData;
  logic              MemWrEn;
  logic [31:0]       MemWrData;
  logic              Done;
  logic              Misaligned;
  logic              Busy;
  logic [1:0]        dbg_state;

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  store_narrow_unit #(.ADDR_W(ADDR_W)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .ReqValid(ReqValid), .ReqReady(ReqReady),
    .ReqAddr(ReqAddr), .ReqData(ReqData), .ReqSize(ReqSize),
    .MemAddr(MemAddr), .MemRdEn(MemRdEn), .MemRdData(MemRdData),
    .MemWrEn(MemWrEn), .MemWrData(MemWrData), .Done(Done),
    .Misaligned(Misaligned), .Busy(Busy), .dbg_state(dbg_state)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] init_word(input int i);
    case (i)
      0:       return 32'h55667788;
      4:       return 32'h11223344;
      8:       return 32'h00000000;
      default: return (32'(i) * 32'h9E3779B9) ^ 32'h5A5A0F0F;
    endcase
  endfunction

  // ---------------- memory environment ----------------
  logic [31:0] mem_env [DEPTH];
  logic        env_init = 1'b0;
  logic [31:0] rd_data = 32'h0;
  assign MemRdData = rd_data;

  always @(posedge Clk) begin
    if (!env_init) begin
      for (int i = 0; i < DEPTH; i++) mem_env[i] = init_word(i);
      env_init = 1'b1;
    end
    if (MemRdEn === 1'b1) rd_data <= mem_env[MemAddr];
    if (MemWrEn === 1'b1) mem_env[MemAddr] = MemWrData;
  end

  // ---------------- reference model ----------------
  // Each accepted request becomes a list of expected per-cycle outputs,
  // derived from the latency and lane rules; the list plays out one entry
  // per cycle and the unit is ready whenever the list is exhausted.
  typedef struct packed {
    logic              rd;
    logic              wr;
    logic              done;
    logic              mis;
    logic [31:0]       wdata;
    logic [ADDR_W-1:0] waddr;
  } exp_t;

  exp_t              sched_q[$];
  exp_t              cur;
  logic              model_ready = 1'b1;
  logic [ADDR_W-1:0] exp_addr = '0;
  logic [31:0]       mem_model [DEPTH];
  logic              model_init = 1'b0;
  logic              armed = 1'b0;
  int                cyc = 0;
  int                done_q[$];

  function automatic exp_t mk(input logic rd, input logic wr, input logic done,
                              input logic mis, input logic [31:0] wdata,
                              input logic [ADDR_W-1:0] waddr);
    exp_t e;
    e.rd = rd; e.wr = wr; e.done = done; e.mis = mis; e.wdata = wdata; e.waddr = waddr;
    return e;
  endfunction

  function automatic logic [31:0] put_bytes(input logic [31:0] old, input logic [31:0] d,
                                            input int first, input int n);
    logic [7:0] b [4];
    for (int k = 0; k < 4; k++) b[k] = old[8*k +: 8];
    for (int k = 0; k < n; k++) b[first+k] = d[8*k +: 8];
    return {b[3], b[2], b[1], b[0]};
  endfunction

  always @(posedge Clk) begin
    logic [ADDR_W-1:0] wa;
    int                off;
    logic [31:0]       nw;
    if (!model_init) begin
      for (int i = 0; i < DEPTH; i++) mem_model[i] = init_word(i);
      model_init = 1'b1;
    end
    cyc++;
    if (!Reset_n) begin
      sched_q.delete();
      cur         = '0;
      model_ready = 1'b1;
      exp_addr    = '0;
      armed       = 1'b1;
    end else if (armed) begin
      if (model_ready && ReqValid === 1'b1) begin
        wa       = ReqAddr[ADDR_W+1:2];
        off      = int'(ReqAddr[1:0]);
        exp_addr = wa;
        case (ReqSize)
          2'b00: begin
            nw = put_bytes(mem_model[wa], ReqData, off, 1);
            sched_q.push_back(mk(1, 0, 0, 0, 32'h0, wa));
            sched_q.push_back(mk(0, 1, 1, 0, nw, wa));
          end
          2'b01: begin
            if (TRAP && (off % 2 == 1)) begin
              sched_q.push_back(mk(0, 0, 1, 1, 32'h0, wa));
            end else begin
              nw = put_bytes(mem_model[wa], ReqData, (off / 2) * 2, 2);
              sched_q.push_back(mk(1, 0, 0, 0, 32'h0, wa));
              sched_q.push_back(mk(0, 1, 1, 0, nw, wa));
            end
          end
          2'b10: begin
            if (TRAP && off != 0) sched_q.push_back(mk(0, 0, 1, 1, 32'h0, wa));
            else                  sched_q.push_back(mk(0, 1, 1, 0, ReqData, wa));
          end
          default: sched_q.push_back(mk(0, 0, 1, 0, 32'h0, wa));
        endcase
      end
      if (sched_q.size() > 0) begin
        cur         = sched_q.pop_front();
        model_ready = 1'b0;
        if (cur.wr) mem_model[cur.waddr] = cur.wdata;
      end else begin
        cur         = '0;
        model_ready = 1'b1;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge Clk) begin
    if (armed) begin
      chk("ready",      32'(ReqReady),   32'(model_ready));
      chk("busy",       32'(Busy),       32'(!model_ready));
      chk("mem_rd_en",  32'(MemRdEn),    32'(cur.rd));
      chk("mem_wr_en",  32'(MemWrEn),    32'(cur.wr));
      chk("done",       32'(Done),       32'(cur.done));
      chk("misaligned", 32'(Misaligned), 32'(cur.mis));
      chk("mem_addr",   32'(MemAddr),    32'(exp_addr));
      if (cur.wr) chk("mem_wr_data", MemWrData, cur.wdata);
      if (Done === 1'b1) done_q.push_back(cyc + 1);
    end
  end

  // ---------------- driver ----------------
  // Called at a falling edge; returns at the falling edge just after the
  // accepting rising edge, with ReqValid still high. acc = accepting edge.
  task automatic send(input logic [31:0] a, input logic [31:0] d,
                      input logic [1:0] s, output int acc);
    int guard = 0;
    ReqValid = 1'b1; ReqAddr = a; ReqData = d; ReqSize = s;
    while (ReqReady !== 1'b1 && guard < 20) begin
      @(negedge Clk);
      guard++;
    end
    if (guard >= 20) begin
      n_cmp++; n_bad++;
      $display("FAIL accept_timeout: got ReqReady=%b expected 1 within 20 cycles", ReqReady);
    end
    acc = cyc + 1;
    @(negedge Clk);
  endtask

  task automatic idle_cycles(input int n);
    ReqValid = 1'b0;
    for (int i = 0; i < n; i++) @(negedge Clk);
  endtask

  int acc0, acc1, acc2, dummy;

  initial begin
    Reset_n = 1'b0; ReqValid = 1'b0; ReqAddr = '0; ReqData = '0; ReqSize = 2'b00;
    repeat (3) @(negedge Clk);
    Reset_n = 1'b1;
    @(negedge Clk);
    chk("rst_ready",  32'(ReqReady),  32'd1);
    chk("rst_busy",   32'(Busy),      32'd0);
    chk("rst_addr",   32'(MemAddr),   32'd0);
    chk("rst_wdata",  MemWrData,      32'h0);
    chk("rst_wr_en",  32'(MemWrEn),   32'd0);

    // SB 0x13: read in N+1, merged write in N+2.
    send(32'h0000_0013, 32'h1234_56AB, 2'b00, dummy);
    ReqValid = 1'b0;
    chk("sb_rd_en",   32'(MemRdEn),   32'd1);
    chk("sb_addr",    32'(MemAddr),   32'd4);
    chk("sb_done_n1", 32'(Done),      32'd0);
    @(negedge Clk);
    chk("sb_wdata",   MemWrData,      32'hAB22_3344);
    chk("sb_done_n2", 32'(Done),      32'd1);
    chk("model_sb",   mem_model[4],   32'hAB22_3344);
    idle_cycles(1);

    // SW 0x10: write and Done in N+1, no read.
    send(32'h0000_0010, 32'hDEAD_BEEF, 2'b10, dummy);
    ReqValid = 1'b0;
    chk("sw_wr_en",   32'(MemWrEn),   32'd1);
    chk("sw_rd_en",   32'(MemRdEn),   32'd0);
    chk("sw_addr",    32'(MemAddr),   32'd4);
    chk("sw_wdata",   MemWrData,      32'hDEAD_BEEF);
    chk("sw_done",    32'(Done),      32'd1);
    @(negedge Clk);
    chk("sw_ready_n2", 32'(ReqReady), 32'd1);

    // SH 0x22 into a zero word.
    send(32'h0000_0022, 32'hFFFF_CAFE, 2'b01, dummy);
    ReqValid = 1'b0;
    chk("sh_rd_en",   32'(MemRdEn),   32'd1);
    @(negedge Clk);
    chk("sh_wdata",   MemWrData,      32'hCAFE_0000);
    chk("sh_addr",    32'(MemAddr),   32'd8);
    idle_cycles(1);

    // SH 0x01: trapped or force-aligned to 0x00.
    send(32'h0000_0001, 32'h1234_BEEF, 2'b01, dummy);
    ReqValid = 1'b0;
    if (TRAP) begin
      chk("shm_done",  32'(Done),       32'd1);
      chk("shm_mis",   32'(Misaligned), 32'd1);
      chk("shm_rd_en", 32'(MemRdEn),    32'd0);
      chk("shm_wr_en", 32'(MemWrEn),    32'd0);
    end else begin
      chk("shm_rd_en", 32'(MemRdEn),    32'd1);
      chk("shm_addr",  32'(MemAddr),    32'd0);
      @(negedge Clk);
      chk("shm_wdata", MemWrData,       32'h5566_BEEF);
      chk("shm_mis",   32'(Misaligned), 32'd0);
    end
    idle_cycles(2);

    // Reset during the READ cycle of an SB: the store must vanish.
    send(32'h0000_0041, 32'h0000_0077, 2'b00, dummy);
    ReqValid = 1'b0;
    Reset_n  = 1'b0;
    repeat (2) @(negedge Clk);
    Reset_n  = 1'b1;
    @(negedge Clk);
    chk("mid_rst_ready", 32'(ReqReady), 32'd1);
    chk("mid_rst_wr_en", 32'(MemWrEn),  32'd0);
    chk("mid_rst_rd_en", 32'(MemRdEn),  32'd0);
    chk("mid_rst_done",  32'(Done),     32'd0);
    chk("mid_rst_wdata", MemWrData,     32'h0);
    chk("mid_rst_addr",  32'(MemAddr),  32'd0);
    chk("mid_rst_mem",   mem_model[16], init_word(16));

    // ReqValid held high across SW, SB, SW.
    done_q.delete();
    send(32'h0000_0100, 32'hA5A5_0001, 2'b10, acc0);
    send(32'h0000_0105, 32'h0000_00C3, 2'b00, acc1);
    send(32'h0000_0108, 32'hA5A5_0003, 2'b10, acc2);
    idle_cycles(6);
    chk("b2b_acc1",   32'(acc1 - acc0),    32'd2);
    chk("b2b_acc2",   32'(acc2 - acc0),    32'd5);
    chk("b2b_ndone",  32'(done_q.size()),  32'd3);
    if (done_q.size() == 3) begin
      chk("b2b_done0", 32'(done_q[0] - acc0), 32'd1);
      chk("b2b_done1", 32'(done_q[1] - acc0), 32'd4);
      chk("b2b_done2", 32'(done_q[2] - acc0), 32'd6);
    end

    // Randomized traffic, gaps and held-valid bursts mixed.
    for (int i = 0; i < 300; i++) begin
      logic [31:0] ra;
      ra = $urandom();
      if ($urandom_range(0, 3) == 0) ra[31:8] = 24'h0;  // revisit low words
      send(ra, $urandom(), 2'($urandom_range(0, 3)), dummy);
      if ($urandom_range(0, 2) != 0) idle_cycles($urandom_range(0, 2));
    end
    idle_cycles(8);

    begin
      int bad_words = 0;
      for (int i = 0; i < DEPTH; i++) if (mem_env[i] !== mem_model[i]) bad_words++;
      chk("final_memory_bad_words", 32'(bad_words), 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Hard stop in case something above stalls.
  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish by 200000");
    n_bad++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "timeout");
  end

endmodule
